// File: rtl/addsub_chain_seq.sv
// Multi-byte add/subtract sequencer driving an external combinational 8-bit addsub
// stage one byte per cycle (LSB first), chaining carries and publishing result + flags.
module addsub_chain_seq #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_sub,
  input  logic         use_carry,
  input  logic         carry_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [7:0]   as_x,
  output logic [7:0]   as_y,
  output logic         as_sub,
  output logic         as_cin,
  output logic         as_carry,
  input  logic [7:0]   as_sum,
  input  logic         as_cout,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cin0_q, cin0_d;
  logic          creg_q, creg_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_out_q, carry_out_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    byte_x, byte_y;

  // Byte-lane select of the latched operands for the current index.
  always_comb begin
    byte_x = '0;
    byte_y = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        byte_x = a_q[8*i +: 8];
        byte_y = b_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    cin0_d      = cin0_q;
    creg_d      = creg_q;
    acc_d       = acc_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    as_x        = '0;
    as_y        = '0;
    as_cin      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          // Subtract is a + ~b + 1, so the adder itself never subtracts.
          b_d     = op_sub ? ~b : b;
          cin0_d  = op_sub | (use_carry & carry_in);
          idx_d   = '0;
          creg_d  = 1'b0;
          acc_d   = '0;
        end
      end
      RUN: begin
        busy   = 1'b1;
        as_x   = byte_x;
        as_y   = byte_y;
        as_cin = (idx_q == '0) ? cin0_q : creg_q;
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) acc_d[8*i +: 8] = as_sum;
        end
        creg_d = as_cout;
        idx_d  = idx_q + 1'b1;
        // Publish on the edge into DONE so result is valid while done is high.
        if (idx_q == LAST) begin
          state_d     = DONE;
          idx_d       = '0;
          result_d    = acc_d;
          carry_out_d = as_cout;
          zero_d      = (acc_d == '0);
          ovf_d       = (byte_x[7] == byte_y[7]) & (as_sum[7] != byte_x[7]);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin0_q      <= 1'b0;
      creg_q      <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin0_q      <= cin0_d;
      creg_q      <= creg_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign as_sub    = 1'b0;
  assign as_carry  = 1'b1;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_chain_seq.sv
// Bench for addsub_chain_seq: directed corner cases plus random operations against
// a whole-word arithmetic reference, with a behavioural 8-bit addsub stage attached.
module tb_addsub_chain_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- NBYTES=4 instance ----------------
  logic        start = 1'b0, op_sub = 1'b0, use_carry = 1'b0, carry_in = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [7:0]  as_x, as_y, as_sum;
  logic        as_sub, as_cin, as_carry, as_cout;
  logic        busy, done, carry_out, zero, ovf;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  addsub_chain_seq #(.NBYTES(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .use_carry(use_carry),
    .carry_in(carry_in), .a(a_in), .b(b_in), .as_x(as_x), .as_y(as_y),
    .as_sub(as_sub), .as_cin(as_cin), .as_carry(as_carry), .as_sum(as_sum),
    .as_cout(as_cout), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .zero(zero), .ovf(ovf), .dbg_state(dbg_state)
  );

  // Behavioural model of the downstream 8-bit addsub stage.
  assign {as_cout, as_sum} = {1'b0, as_x} + {1'b0, as_sub ? ~as_y : as_y}
                           + {8'b0, as_carry ? as_cin : as_sub};

  // ---------------- NBYTES=1 instance ----------------
  logic       start1 = 1'b0, op_sub1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic [7:0] as_x1, as_y1, as_sum1, result1;
  logic       as_sub1, as_cin1, as_carry1, as_cout1;
  logic       busy1, done1, carry_out1, zero1, ovf1;
  logic [1:0] dbg_state1;

  addsub_chain_seq #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub1), .use_carry(1'b0),
    .carry_in(1'b0), .a(a1), .b(b1), .as_x(as_x1), .as_y(as_y1),
    .as_sub(as_sub1), .as_cin(as_cin1), .as_carry(as_carry1), .as_sum(as_sum1),
    .as_cout(as_cout1), .busy(busy1), .done(done1), .result(result1),
    .carry_out(carry_out1), .zero(zero1), .ovf(ovf1), .dbg_state(dbg_state1)
  );

  assign {as_cout1, as_sum1} = {1'b0, as_x1} + {1'b0, as_sub1 ? ~as_y1 : as_y1}
                             + {8'b0, as_carry1 ? as_cin1 : as_sub1};

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (whole-word arithmetic) ----------------
  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        z;
    logic        ov;
  } ref_t;

  function automatic ref_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic uc, input logic ci);
    ref_t r;
    logic signed [33:0] sa, sb, sr;
    logic [32:0] wide;
    sa = $signed({{2{a[31]}}, a});
    sb = $signed({{2{b[31]}}, b});
    if (sub) begin
      r.res = a - b;
      r.co  = (a >= b);
      sr    = sa - sb;
    end else begin
      wide  = {1'b0, a} + {1'b0, b} + 33'(uc & ci);
      r.res = wide[31:0];
      r.co  = wide[32];
      sr    = sa + sb + 34'(uc & ci);
    end
    r.z  = (r.res == 32'd0);
    r.ov = (sr > 34'sd2147483647) || (sr < -34'sd2147483648);
    return r;
  endfunction

  // ---------------- driver: one NBYTES=4 operation ----------------
  // poke: re-assert start with other operands while the op is running.
  task automatic run4(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic uc, input logic ci, input bit poke);
    ref_t        e;
    logic [31:0] b_eff;
    e     = ref_op(a, b, sub, uc, ci);
    b_eff = sub ? ~b : b;
    @(negedge clk);
    a_in = a; b_in = b; op_sub = sub; use_carry = uc; carry_in = ci; start = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) start = 1'b0;
      if (poke && k == 1) begin
        a_in = $urandom; b_in = $urandom; op_sub = ~sub; start = 1'b1;
      end
      if (poke && k == 3) start = 1'b0;
      chk({nm, ".busy"}, 64'(busy), 64'(k < 4));
      chk({nm, ".done"}, 64'(done), 64'(k == 4));
      if (k < 4) begin
        chk({nm, ".as_x"}, 64'(as_x), 64'(a[8*k +: 8]));
        chk({nm, ".as_y"}, 64'(as_y), 64'(b_eff[8*k +: 8]));
      end
      if (k == 0) chk({nm, ".cin0"}, 64'(as_cin), 64'(sub | (uc & ci)));
      if (k >= 4) begin
        chk({nm, ".result"}, 64'(result), 64'(e.res));
        chk({nm, ".carry_out"}, 64'(carry_out), 64'(e.co));
        chk({nm, ".zero"}, 64'(zero), 64'(e.z));
        chk({nm, ".ovf"}, 64'(ovf), 64'(e.ov));
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit saw_done;
    logic [31:0] ra, rb;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.flags", {61'd0, carry_out, zero, ovf}, 64'd0);
    chk("rst.as_x", 64'(as_x), 64'd0);
    chk("rst.as_cin", 64'(as_cin), 64'd0);
    chk("tie.as_sub", 64'(as_sub), 64'd0);
    chk("tie.as_carry", 64'(as_carry), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed corners, including explicit expected constants.
    run4("t1_add", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_const", 64'(result), 64'h0000_0100);
    run4("t2_sub", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_const", 64'(result), 64'hFFFF_FFFF);
    run4("t3_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_const", {31'd0, result, carry_out, zero}, {31'd0, 32'h0, 1'b1, 1'b1});
    run4("t4_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_const", {31'd0, result, ovf, carry_out}, {31'd0, 32'h8000_0000, 1'b1, 1'b0});
    run4("sub_cin_ignored", 32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 1'b1, 1'b0);

    // start during RUN must be ignored.
    run4("t5_poke", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_idle_after_poke", 64'(busy), 64'd0);

    // Reset mid-RUN: in-flight op discarded, no done.
    @(negedge clk);
    a_in = 32'hDEAD_BEEF; b_in = 32'h0101_0101; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst.busy", 64'(busy), 64'd0);
    chk("t5_rst.done", 64'(done), 64'd0);
    chk("t5_rst.result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("t5_rst.no_done", 64'(saw_done), 64'd0);
    run4("t5_after_rst", 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random operations, with some boundary operand values mixed in.
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = ra;
        default: ;
      endcase
      run4("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    // NBYTES=1: sub 0x80 - 0x01.
    @(negedge clk);
    a1 = 8'h80; b1 = 8'h01; op_sub1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("t6.busy", 64'(busy1), 64'd1);
    chk("t6.done_early", 64'(done1), 64'd0);
    @(posedge clk); #1;
    chk("t6.done", 64'(done1), 64'd1);
    chk("t6.result", 64'(result1), 64'h7F);
    chk("t6.carry_out", 64'(carry_out1), 64'd1);
    chk("t6.ovf", 64'(ovf1), 64'd1);
    chk("t6.zero", 64'(zero1), 64'd0);
    @(posedge clk); #1;
    chk("t6.done_pulse", 64'(done1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the sequence is a few thousand cycles at most.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
